// File: rtl/operand_fetch.sv
// Register-read / issue stage for the dual-issue core.
// Bypasses writebacks, tracks busy GPRs and splits conflicting bundles.
module operand_fetch #(
  parameter int NWB  = 4,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [31:0]          dec_pc,
  input  logic [63:0]          dec_inst,
  input  logic [4:0]           u_ra,
  input  logic                 u_ra_flag,
  input  logic [4:0]           u_rb,
  input  logic                 u_rb_flag,
  input  logic [4:0]           u_rt,
  input  logic                 u_rt_flag,
  input  logic [4:0]           l_ra,
  input  logic                 l_ra_flag,
  input  logic [4:0]           l_rb,
  input  logic                 l_rb_flag,
  input  logic [4:0]           l_rt,
  input  logic                 l_rt_flag,
  input  logic [NREG*32-1:0]   gpr_q,
  input  logic [NWB-1:0]       wb_valid,
  input  logic [NWB*5-1:0]     wb_rt,
  input  logic [NWB*32-1:0]    wb_data,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [31:0]          ex_pc,
  output logic [63:0]          ex_inst,
  output logic [31:0]          ex_u_a,
  output logic [31:0]          ex_u_b,
  output logic [31:0]          ex_l_a,
  output logic [31:0]          ex_l_b,
  output logic [4:0]           ex_u_rt,
  output logic                 ex_u_rt_flag,
  output logic [4:0]           ex_l_rt,
  output logic                 ex_l_rt_flag,
  output logic [NREG-1:0]      busy_vec
);

  localparam logic [0:0] FULL  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  function automatic logic [31:0] f_rd(
    input logic [4:0]         s,
    input logic               f,
    input logic [NREG*32-1:0] q,
    input logic [NWB-1:0]     v,
    input logic [NWB*5-1:0]   rt,
    input logic [NWB*32-1:0]  d
  );
    logic [31:0] r;
    r = q[32*s +: 32];
    // Later ports overwrite earlier ones: highest index wins.
    for (int k = 0; k < NWB; k++)
      if (v[k] && rt[5*k +: 5] == s)
        r = d[32*k +: 32];
    if (!f)
      r = '0;
    return r;
  endfunction

  logic [0:0]      r_state;
  logic [NREG-1:0] r_busy;
  logic            r_ex_valid;
  logic [31:0]     r_pc;
  logic [63:0]     r_inst;
  logic [31:0]     r_ua, r_ub, r_la, r_lb;
  logic [4:0]      r_urt, r_lrt;
  logic            r_urtf, r_lrtf;

  logic [NREG-1:0] w_clr, w_set, w_bz;
  logic [31:0]     w_ua, w_ub, w_la, w_lb;
  logic            w_hz_u, w_hz_l, w_hz;
  logic            w_conf, w_slot, w_issue;
  logic            w_iu, w_il;
  logic [0:0]      w_state_nx;

  always_comb begin
    w_clr = '0;
    for (int k = 0; k < NWB; k++)
      if (wb_valid[k])
        w_clr[wb_rt[5*k +: 5]] = 1'b1;
  end

  assign w_bz = r_busy & ~w_clr;

  assign w_ua = f_rd(u_ra, u_ra_flag, gpr_q, wb_valid, wb_rt, wb_data);
  assign w_ub = f_rd(u_rb, u_rb_flag, gpr_q, wb_valid, wb_rt, wb_data);
  assign w_la = f_rd(l_ra, l_ra_flag, gpr_q, wb_valid, wb_rt, wb_data);
  assign w_lb = f_rd(l_rb, l_rb_flag, gpr_q, wb_valid, wb_rt, wb_data);

  assign w_hz_u = (u_ra_flag & w_bz[u_ra]) |
                  (u_rb_flag & w_bz[u_rb]) |
                  (u_rt_flag & w_bz[u_rt]);
  assign w_hz_l = (l_ra_flag & w_bz[l_ra]) |
                  (l_rb_flag & w_bz[l_rb]) |
                  (l_rt_flag & w_bz[l_rt]);

  assign w_conf = u_rt_flag &
                  ((l_ra_flag & (u_rt == l_ra)) |
                   (l_rb_flag & (u_rt == l_rb)) |
                   (l_rt_flag & (u_rt == l_rt)));

  assign w_iu = (r_state == FULL);
  assign w_il = (r_state == SPLIT) | ~w_conf;

  // In SPLIT only the lower half remains; busy already reflects the upper rt.
  assign w_hz = (w_iu & w_hz_u) | (w_il & w_hz_l);

  assign w_slot    = ~r_ex_valid | ex_ready;
  assign w_issue   = dec_valid & w_slot & ~w_hz;
  assign dec_ready = ~rst & w_issue & w_il;

  always_comb begin
    w_state_nx = r_state;
    if (w_issue)
      w_state_nx = (r_state == FULL && w_conf) ? SPLIT : FULL;
  end

  always_comb begin
    w_set = '0;
    if (w_issue && w_iu && u_rt_flag)
      w_set[u_rt] = 1'b1;
    if (w_issue && w_il && l_rt_flag)
      w_set[l_rt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FULL;
      r_busy     <= '0;
      r_ex_valid <= 1'b0;
      r_pc       <= '0;
      r_inst     <= '0;
      r_ua       <= '0;
      r_ub       <= '0;
      r_la       <= '0;
      r_lb       <= '0;
      r_urt      <= '0;
      r_lrt      <= '0;
      r_urtf     <= 1'b0;
      r_lrtf     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= w_bz | w_set;
      if (w_issue) begin
        r_ex_valid <= 1'b1;
        r_pc       <= dec_pc;
        r_inst     <= {w_iu ? dec_inst[63:32] : 32'h0,
                       w_il ? dec_inst[31:0]  : 32'h0};
        r_ua       <= w_iu ? w_ua : '0;
        r_ub       <= w_iu ? w_ub : '0;
        r_urt      <= w_iu ? u_rt : '0;
        r_urtf     <= w_iu & u_rt_flag;
        r_la       <= w_il ? w_la : '0;
        r_lb       <= w_il ? w_lb : '0;
        r_lrt      <= w_il ? l_rt : '0;
        r_lrtf     <= w_il & l_rt_flag;
      end else if (w_slot) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_pc        = r_pc;
  assign ex_inst      = r_inst;
  assign ex_u_a       = r_ua;
  assign ex_u_b       = r_ub;
  assign ex_l_a       = r_la;
  assign ex_l_b       = r_lb;
  assign ex_u_rt      = r_urt;
  assign ex_u_rt_flag = r_urtf;
  assign ex_l_rt      = r_lrt;
  assign ex_l_rt_flag = r_lrtf;
  assign busy_vec     = r_busy;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed-vector bench for operand_fetch.
// GPR i holds 0xC0DE0000 | i throughout.
module tb_operand_fetch;
  localparam int NWB  = 4;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_ready;
  logic [31:0] dec_pc;
  logic [63:0] dec_inst;
  logic [4:0] u_ra, u_rb, u_rt, l_ra, l_rb, l_rt;
  logic u_ra_flag, u_rb_flag, u_rt_flag;
  logic l_ra_flag, l_rb_flag, l_rt_flag;
  logic [NREG*32-1:0] gpr_q;
  logic [NWB-1:0] wb_valid;
  logic [NWB*5-1:0] wb_rt;
  logic [NWB*32-1:0] wb_data;
  logic ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_u_a, ex_u_b, ex_l_a, ex_l_b;
  logic [63:0] ex_inst;
  logic [4:0] ex_u_rt, ex_l_rt;
  logic ex_u_rt_flag, ex_l_rt_flag;
  logic [NREG-1:0] busy_vec;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_fetch #(.NWB(NWB), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_inst(dec_inst),
    .u_ra(u_ra), .u_ra_flag(u_ra_flag),
    .u_rb(u_rb), .u_rb_flag(u_rb_flag),
    .u_rt(u_rt), .u_rt_flag(u_rt_flag),
    .l_ra(l_ra), .l_ra_flag(l_ra_flag),
    .l_rb(l_rb), .l_rb_flag(l_rb_flag),
    .l_rt(l_rt), .l_rt_flag(l_rt_flag),
    .gpr_q(gpr_q),
    .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_u_a(ex_u_a), .ex_u_b(ex_u_b),
    .ex_l_a(ex_l_a), .ex_l_b(ex_l_b),
    .ex_u_rt(ex_u_rt), .ex_u_rt_flag(ex_u_rt_flag),
    .ex_l_rt(ex_l_rt), .ex_l_rt_flag(ex_l_rt_flag),
    .busy_vec(busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bu(input logic [4:0] ra, input logic raf,
                    input logic [4:0] rb, input logic rbf,
                    input logic [4:0] rt, input logic rtf);
    u_ra = ra; u_ra_flag = raf;
    u_rb = rb; u_rb_flag = rbf;
    u_rt = rt; u_rt_flag = rtf;
  endtask

  task automatic bl(input logic [4:0] ra, input logic raf,
                    input logic [4:0] rb, input logic rbf,
                    input logic [4:0] rt, input logic rtf);
    l_ra = ra; l_ra_flag = raf;
    l_rb = rb; l_rb_flag = rbf;
    l_rt = rt; l_rt_flag = rtf;
  endtask

  task automatic set_wb(input int k, input logic [4:0] rt,
                        input logic [31:0] d);
    wb_valid[k] = 1'b1;
    wb_rt[5*k +: 5] = rt;
    wb_data[32*k +: 32] = d;
  endtask

  task automatic idle();
    dec_valid = 1'b0;
    dec_pc = '0;
    dec_inst = '0;
    bu(0, 0, 0, 0, 0, 0);
    bl(0, 0, 0, 0, 0, 0);
    wb_valid = '0;
    wb_rt = '0;
    wb_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++)
      gpr_q[32*i +: 32] = 32'hC0DE_0000 | i;
    rst = 1'b1;
    ex_ready = 1'b1;
    idle();
    dec_valid = 1'b1;
    #12;
    chk("rst_ready", dec_ready, 0);
    chk("rst_valid", ex_valid, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_pc", ex_pc, 0);
    rst = 1'b0;

    // 1: plain dual issue
    dec_valid = 1'b1;
    dec_pc = 32'h100;
    dec_inst = 64'h1111_2222_3333_4444;
    bu(1, 1, 2, 1, 3, 1);
    bl(5, 1, 6, 1, 4, 1);
    #1 chk("t1_ready", dec_ready, 1);
    tick();
    idle();
    chk("t1_valid", ex_valid, 1);
    chk("t1_pc", ex_pc, 32'h100);
    chk("t1_inst", ex_inst, 64'h1111_2222_3333_4444);
    chk("t1_ua", ex_u_a, 32'hC0DE_0001);
    chk("t1_ub", ex_u_b, 32'hC0DE_0002);
    chk("t1_la", ex_l_a, 32'hC0DE_0005);
    chk("t1_lb", ex_l_b, 32'hC0DE_0006);
    chk("t1_urt", {ex_u_rt_flag, ex_u_rt}, {1'b1, 5'd3});
    chk("t1_lrt", {ex_l_rt_flag, ex_l_rt}, {1'b1, 5'd4});
    chk("t1_busy", busy_vec, 32'h18);

    // 2: same-cycle wb clears hazard; highest port wins
    dec_valid = 1'b1;
    dec_pc = 32'h200;
    bu(3, 1, 0, 0, 9, 1);
    set_wb(0, 3, 32'h1111_1111);
    set_wb(2, 3, 32'hDEAD_BEEF);
    #1 chk("t2_ready", dec_ready, 1);
    tick();
    idle();
    chk("t2_valid", ex_valid, 1);
    chk("t2_ua", ex_u_a, 32'hDEAD_BEEF);
    chk("t2_ub_unused", ex_u_b, 0);
    chk("t2_busy", busy_vec, 32'h210);

    // 3: stall on busy r7 for 5 cycles
    do_reset();
    dec_valid = 1'b1;
    bu(0, 0, 0, 0, 7, 1);
    #1 chk("t3_wr_ready", dec_ready, 1);
    tick();
    dec_pc = 32'h300;
    bu(7, 1, 0, 0, 10, 1);
    for (int i = 0; i < 5; i++) begin
      #1 chk("t3_stall_ready", dec_ready, 0);
      tick();
      chk("t3_stall_valid", ex_valid, 0);
    end
    set_wb(1, 7, 32'h7777_7777);
    #1 chk("t3_go_ready", dec_ready, 1);
    tick();
    idle();
    chk("t3_valid", ex_valid, 1);
    chk("t3_ua", ex_u_a, 32'h7777_7777);
    chk("t3_pc", ex_pc, 32'h300);
    chk("t3_busy", busy_vec, 32'h400);

    // 4: intra-bundle split
    do_reset();
    dec_valid = 1'b1;
    dec_pc = 32'h400;
    dec_inst = 64'hAAAA_AAAA_BBBB_BBBB;
    bu(1, 1, 0, 0, 8, 1);
    bl(8, 1, 0, 0, 11, 1);
    #1 chk("t4_up_ready", dec_ready, 0);
    tick();
    chk("t4_up_valid", ex_valid, 1);
    chk("t4_up_inst", ex_inst, 64'hAAAA_AAAA_0000_0000);
    chk("t4_up_lrtf", ex_l_rt_flag, 0);
    chk("t4_up_ua", ex_u_a, 32'hC0DE_0001);
    chk("t4_up_busy", busy_vec, 32'h100);
    for (int i = 0; i < 2; i++) begin
      #1 chk("t4_stall_ready", dec_ready, 0);
      tick();
      chk("t4_stall_valid", ex_valid, 0);
    end
    set_wb(3, 8, 32'h8888_8888);
    #1 chk("t4_lo_ready", dec_ready, 1);
    tick();
    idle();
    chk("t4_lo_valid", ex_valid, 1);
    chk("t4_lo_inst", ex_inst, 64'h0000_0000_BBBB_BBBB);
    chk("t4_lo_la", ex_l_a, 32'h8888_8888);
    chk("t4_lo_urtf", ex_u_rt_flag, 0);
    chk("t4_lo_lrt", {ex_l_rt_flag, ex_l_rt}, {1'b1, 5'd11});
    chk("t4_lo_busy", busy_vec, 32'h800);
    dec_valid = 1'b1;
    #1 chk("t4_full_ready", dec_ready, 1);
    tick();
    idle();

    // 5: exec backpressure holds the issue register
    do_reset();
    dec_valid = 1'b1;
    dec_pc = 32'h500;
    bu(1, 1, 0, 0, 12, 1);
    bl(0, 0, 2, 1, 13, 1);
    tick();
    ex_ready = 1'b0;
    dec_pc = 32'h600;
    bu(0, 0, 0, 0, 0, 0);
    bl(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_ready", dec_ready, 0);
      tick();
      chk("t5_valid", ex_valid, 1);
      chk("t5_pc", ex_pc, 32'h500);
      chk("t5_ua", ex_u_a, 32'hC0DE_0001);
      chk("t5_lb", ex_l_b, 32'hC0DE_0002);
      chk("t5_busy", busy_vec, 32'h3000);
    end
    ex_ready = 1'b1;
    #1 chk("t5_rel_ready", dec_ready, 1);
    tick();
    idle();
    chk("t5_rel_pc", ex_pc, 32'h600);

    // 6: async reset while split with busy = 0xFF
    do_reset();
    dec_valid = 1'b1;
    dec_inst = 64'h5555_5555_6666_6666;
    bu(0, 0, 0, 0, 0, 1); bl(0, 0, 0, 0, 1, 1); tick();
    bu(0, 0, 0, 0, 2, 1); bl(0, 0, 0, 0, 3, 1); tick();
    bu(0, 0, 0, 0, 4, 1); bl(0, 0, 0, 0, 5, 1); tick();
    bu(0, 0, 0, 0, 6, 1); bl(0, 0, 0, 0, 0, 0); tick();
    bu(0, 0, 0, 0, 7, 1); bl(0, 0, 0, 0, 7, 1); tick();
    chk("t6_busy_ff", busy_vec, 32'hFF);
    chk("t6_split_inst", ex_inst, 64'h5555_5555_0000_0000);
    #1 chk("t6_split_ready", dec_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", ex_valid, 0);
    chk("t6_rst_busy", busy_vec, 0);
    chk("t6_rst_ready", dec_ready, 0);
    rst = 1'b0;
    #1 chk("t6_full_ready", dec_ready, 0);
    tick();
    idle();
    chk("t6_full_inst", ex_inst, 64'h5555_5555_0000_0000);
    chk("t6_full_busy", busy_vec, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
